// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and request classification for the load/store access controller.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_e;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  // Only the two low address bits matter for halfword/word alignment.
  function automatic logic is_misaligned(input logic [1:0] addr, input logic [2:0] funct3);
    case (funct3[1:0])
      2'b01:   return addr[0];
      2'b10:   return addr != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) return funct3 == FUNCT3_SB || funct3 == FUNCT3_SH || funct3 == FUNCT3_SW;
    return funct3 == FUNCT3_LB || funct3 == FUNCT3_LH || funct3 == FUNCT3_LW ||
           funct3 == FUNCT3_LBU || funct3 == FUNCT3_LHU;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of byte-assembled load data according to the original load funct3.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (funct3_i)
      FUNCT3_LB:  data_o = {{24{data_i[7]}}, data_i[7:0]};
      FUNCT3_LH:  data_o = {{16{data_i[15]}}, data_i[15:0]};
      FUNCT3_LBU: data_o = {24'b0, data_i[7:0]};
      FUNCT3_LHU: data_o = {16'b0, data_i[15:0]};
      default:    data_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu_access_ctrl.sv
// Load/store access controller: one request at a time, aligned accesses in one memory cycle,
// misaligned halfword/word accesses optionally split into sequential byte operations.
module lsu_access_ctrl
  import lsu_pkg::*;
#(
  parameter int AWIDTH           = 32,
  parameter int DWIDTH           = 32,
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [AWIDTH-1:0] req_addr_i,
  input  logic [DWIDTH-1:0] req_wdata_i,
  input  logic [2:0]        req_funct3_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DWIDTH-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d, split_q, split_d, err_q, err_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, buf_q, buf_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        k_q, k_d, last_k;
  logic [DWIDTH-1:0] asm_data, ext_data;
  logic              in_acc;

  assign in_acc = state_q == ACCESS;
  assign last_k = (f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;

  // Byte buffer with the byte arriving this cycle already merged in, so the
  // final byte can be extended and captured on the same edge.
  always_comb begin
    asm_data = buf_q;
    asm_data[{k_q, 3'b000} +: 8] = mem_data_i[7:0];
  end

  lsu_load_extend u_ext (
    .data_i   (asm_data),
    .funct3_i (f3_q),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    split_d = split_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    buf_d   = buf_q;
    f3_d    = f3_q;
    k_d     = k_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        we_d    = req_we_i;
        addr_d  = req_addr_i;
        wdata_d = req_wdata_i;
        f3_d    = req_funct3_i;
        rdata_d = '0;
        buf_d   = '0;
        k_d     = 2'd0;
        split_d = is_misaligned(req_addr_i[1:0], req_funct3_i);
        err_d   = !is_legal(req_we_i, req_funct3_i) ||
                  (is_misaligned(req_addr_i[1:0], req_funct3_i) && !SPLIT_MISALIGNED);
        state_d = err_d ? RESP : ACCESS;
      end
      ACCESS: if (!split_q) begin
        if (!we_q) rdata_d = mem_data_i;
        state_d = RESP;
      end else begin
        buf_d = asm_data;
        k_d   = k_q + 2'd1;
        if (k_q == last_k) begin
          if (!we_q) rdata_d = ext_data;
          state_d = RESP;
        end
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      buf_q   <= '0;
      f3_q    <= 3'b000;
      k_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      split_q <= split_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      buf_q   <= buf_d;
      f3_q    <= f3_d;
      k_q     <= k_d;
    end
  end

  assign req_ready_o = state_q == IDLE;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // Enables are gated by reset so an aborted access never writes in the reset cycle.
  assign mem_read_en_o  = in_acc && !we_q && !rst;
  assign mem_write_en_o = in_acc && we_q && !rst;
  assign mem_addr_o     = in_acc ? addr_q + (split_q ? AWIDTH'(k_q) : '0) : '0;
  assign mem_funct3_o   = !in_acc ? 3'b000 : (!split_q ? f3_q : (we_q ? FUNCT3_SB : FUNCT3_LBU));
  assign mem_data_o     = !in_acc ? '0 :
                          (split_q ? {{(DWIDTH-8){1'b0}}, wdata_q[{k_q, 3'b000} +: 8]} : wdata_q);

endmodule
